// File: rtl/sys_bus_pkg.sv
// Shared types for the system RAM bus arbiter: FSM state encoding, bus-owner
// select codes and the counter width helper.
package sys_bus_pkg;

    typedef enum logic [2:0] {
        CPU_OWN  = 3'd0,
        HANDOVER = 3'd1,
        DMA_OWN  = 3'd2,
        RELEASE  = 3'd3,
        COOLDOWN = 3'd4
    } arb_state_t;

    typedef logic [1:0] owner_t;

    localparam owner_t OWNER_CPU  = 2'd0;
    localparam owner_t OWNER_DMA  = 2'd1;
    localparam owner_t OWNER_NONE = 2'd2;

    // Width able to hold max(a, b) without wrapping; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sys_bus_mux.sv
// Combinational owner select for the RAM address/control/write-data lines.
// OWNER_NONE (and any unused code) drives every line low.
module sys_bus_mux
    import sys_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  owner_t            owner,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_cs,
    input  logic              cpu_write_en,
    input  logic              cpu_oe,
    input  logic [DATA_W-1:0] cpu_databus_out,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic              dma_cs,
    input  logic              dma_write_en,
    input  logic              dma_oe,
    input  logic [DATA_W-1:0] dma_databus_out,
    output logic [ADDR_W-1:0] address,
    output logic              cs,
    output logic              write_en,
    output logic              oe,
    output logic [DATA_W-1:0] databus_out
);

    always_comb begin
        address     = '0;
        cs          = 1'b0;
        write_en    = 1'b0;
        oe          = 1'b0;
        databus_out = '0;
        case (owner)
            OWNER_CPU: begin
                address     = cpu_address;
                cs          = cpu_cs;
                write_en    = cpu_write_en;
                oe          = cpu_oe;
                databus_out = cpu_databus_out;
            end
            OWNER_DMA: begin
                address     = dma_address;
                cs          = dma_cs;
                write_en    = dma_write_en;
                oe          = dma_oe;
                databus_out = dma_databus_out;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// CPU/DMA arbiter for the shared system RAM bus with bounded DMA tenure and a
// CPU cooldown window. Define SYS_BUS_ARB_STATS_EN to add grant/preempt counters.
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned MAX_DMA_CYCLES = 16,
    parameter int unsigned CPU_MIN_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Cpu_Idle,
    input  logic [ADDR_W-1:0] Cpu_Address,
    input  logic              Cpu_Cs,
    input  logic              Cpu_Write_en,
    input  logic              Cpu_Oe,
    input  logic [DATA_W-1:0] Cpu_Databus_out,
    input  logic              Dma_Bus_req,
    input  logic [ADDR_W-1:0] Dma_Address,
    input  logic              Dma_Cs,
    input  logic              Dma_Write_en,
    input  logic              Dma_Oe,
    input  logic [DATA_W-1:0] Dma_Databus_out,
    output logic              Dma_Bus_ack,
    output logic              Dma_Preempt,
    output logic              Cpu_Hold,
`ifdef SYS_BUS_ARB_STATS_EN
    output logic [15:0]       Dma_Grant_count,
    output logic [7:0]        Preempt_count,
`endif
    output logic [ADDR_W-1:0] Address,
    output logic              Cs,
    output logic              Write_en,
    output logic              Oe,
    output logic [DATA_W-1:0] Databus_out
);

    localparam int unsigned CNT_W = cnt_width(MAX_DMA_CYCLES, CPU_MIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DMA_LAST =
        (MAX_DMA_CYCLES == 0) ? '0 : CNT_W'(MAX_DMA_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST =
        (CPU_MIN_CYCLES == 0) ? '0 : CNT_W'(CPU_MIN_CYCLES - 1);
    localparam bit LIMIT_EN = (MAX_DMA_CYCLES != 0);
    localparam bit COOL_EN  = (CPU_MIN_CYCLES != 0);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;
    owner_t           owner;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= CPU_OWN;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        preempt_d = 1'b0;
        case (state_q)
            CPU_OWN: begin
                if (Dma_Bus_req) state_d = HANDOVER;
            end
            HANDOVER: begin
                // A withdrawn request wins over an idle CPU.
                if (!Dma_Bus_req) state_d = CPU_OWN;
                else if (Cpu_Idle) state_d = DMA_OWN;
            end
            DMA_OWN: begin
                if (!Dma_Bus_req) begin
                    state_d = RELEASE;
                end else if (LIMIT_EN && (cnt_q == DMA_LAST)) begin
                    state_d   = RELEASE;
                    preempt_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d = COOL_EN ? COOLDOWN : CPU_OWN;
            end
            COOLDOWN: begin
                if (cnt_q >= COOL_LAST) state_d = CPU_OWN;
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    // Cleared on entry to a timed state, counts while staying, saturates.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == DMA_OWN) || (state_q == COOLDOWN))) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        owner = OWNER_CPU;
        case (state_q)
            DMA_OWN: owner = OWNER_DMA;
            RELEASE: owner = OWNER_NONE;
            default: ;
        endcase
    end

    assign Dma_Bus_ack = (state_q == DMA_OWN);
    assign Cpu_Hold    = (state_q == HANDOVER) || (state_q == DMA_OWN) || (state_q == RELEASE);
    assign Dma_Preempt = preempt_q;

`ifdef SYS_BUS_ARB_STATS_EN
    logic [15:0] grant_cnt_q;
    logic [7:0]  preempt_cnt_q;

    // Preempts are counted as the pulse is launched so the count lines up with it.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            grant_cnt_q   <= '0;
            preempt_cnt_q <= '0;
        end else begin
            if ((state_q == HANDOVER) && (state_d == DMA_OWN) && (grant_cnt_q != 16'hFFFF)) begin
                grant_cnt_q <= grant_cnt_q + 16'd1;
            end
            if (preempt_d && (preempt_cnt_q != 8'hFF)) begin
                preempt_cnt_q <= preempt_cnt_q + 8'd1;
            end
        end
    end

    assign Dma_Grant_count = grant_cnt_q;
    assign Preempt_count   = preempt_cnt_q;
`endif

    sys_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .owner           (owner),
        .cpu_address     (Cpu_Address),
        .cpu_cs          (Cpu_Cs),
        .cpu_write_en    (Cpu_Write_en),
        .cpu_oe          (Cpu_Oe),
        .cpu_databus_out (Cpu_Databus_out),
        .dma_address     (Dma_Address),
        .dma_cs          (Dma_Cs),
        .dma_write_en    (Dma_Write_en),
        .dma_oe          (Dma_Oe),
        .dma_databus_out (Dma_Databus_out),
        .address         (Address),
        .cs              (Cs),
        .write_en        (Write_en),
        .oe              (Oe),
        .databus_out     (Databus_out)
    );

endmodule
